// File: rtl/sprite_snapshot_ctrl_pkg.sv
// Shared types and constants for the sprite snapshot controller.
// States ARMED and CLEAR are only reached when SNAP_WAIT_DONE_EN is defined.
package sprite_snapshot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_COPY,
    ST_CLEAR,
    ST_SWAP
  } state_t;

  // Register the CPU writes to release an armed copy; cleared by the engine.
  localparam int unsigned DONE_IDX         = 17;
  localparam int unsigned NUM_REGS_DEFAULT = 17;

endpackage

// File: rtl/sprite_snapshot_ctrl_snapshot_bank.sv
// Double-buffered sprite shadow: writes land in the back bank, reads come
// combinationally from the front bank, swap flips which bank is front.
module snapshot_bank
  import sprite_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              swap,
  input  logic [4:0]        raddr,
  output logic [DATA_W-1:0] rdata
);

  logic              front_sel;
  logic [DATA_W-1:0] mem [2][NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      front_sel <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else begin
      if (we) begin
        mem[~front_sel][waddr] <= wdata;
      end
      if (swap) begin
        front_sel <= ~front_sel;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (32'(raddr) < NUM_REGS) begin
      rdata = mem[front_sel][raddr];
    end
  end

endmodule

// File: rtl/sprite_snapshot_ctrl.sv
// Arbitrates the sprite register-file port between the CPU and a frame-start
// copy engine; optional SNAP_WAIT_DONE_EN gates the copy on a CPU write to reg 17.
module sprite_snapshot_ctrl
  import sprite_snapshot_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS    = NUM_REGS_DEFAULT,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_dout,
  input  logic [4:0]        shadow_addr,
  output logic [DATA_W-1:0] shadow_data,
  output logic              snap_busy,
  output logic              snap_done,
  output logic              snap_overrun
);

  localparam int unsigned SC_W = $clog2(STALL_LIMIT + 1);

  state_t          state;
  logic [4:0]      idx;
  logic [SC_W-1:0] stall_cnt;
  logic            cpu_act;
  logic            grant;
  logic            last_copy;
  logic            bank_we;
  logic            bank_swap;

  assign cpu_act   = cpu_we | cpu_re;
  assign grant     = ((state == ST_COPY) || (state == ST_CLEAR)) &&
                     (!cpu_act || (stall_cnt == SC_W'(STALL_LIMIT)));
  assign last_copy = (idx == 5'(NUM_REGS - 1));
  assign bank_we   = grant && (state == ST_COPY);
  assign cpu_dout  = rf_dout;

  // The bank flips on the edge entering SWAP, so snap_done and new data coincide.
`ifdef SNAP_WAIT_DONE_EN
  logic start_req;
  assign start_req = cpu_we && (cpu_addr == ADDR_W'(DONE_IDX)) && (cpu_din != '0);
  assign bank_swap = grant && (state == ST_CLEAR);
`else
  assign bank_swap = bank_we && last_copy;
`endif

  always_comb begin
    rf_addr   = cpu_addr;
    rf_din    = cpu_din;
    rf_we     = cpu_we;
    cpu_stall = 1'b0;
    if (grant) begin
      cpu_stall = cpu_act;
      rf_din    = '0;
      rf_we     = (state == ST_CLEAR);
      rf_addr   = (state == ST_CLEAR) ? ADDR_W'(DONE_IDX) : ADDR_W'(idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      stall_cnt    <= '0;
      snap_busy    <= 1'b0;
      snap_done    <= 1'b0;
      snap_overrun <= 1'b0;
    end else begin
      snap_done <= 1'b0;
      if (vsync && (snap_busy || (state == ST_SWAP))) begin
        snap_overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (vsync) begin
            idx       <= '0;
            stall_cnt <= '0;
            snap_busy <= 1'b1;
`ifdef SNAP_WAIT_DONE_EN
            state     <= ST_ARMED;
`else
            state     <= ST_COPY;
`endif
          end
        end
`ifdef SNAP_WAIT_DONE_EN
        ST_ARMED: begin
          if (start_req) begin
            state <= ST_COPY;
          end
        end
        ST_CLEAR: begin
          if (grant) begin
            stall_cnt <= '0;
            snap_busy <= 1'b0;
            snap_done <= 1'b1;
            state     <= ST_SWAP;
          end else begin
            stall_cnt <= stall_cnt + SC_W'(1);
          end
        end
`endif
        ST_COPY: begin
          if (grant) begin
            stall_cnt <= '0;
            idx       <= idx + 5'd1;
            if (last_copy) begin
`ifdef SNAP_WAIT_DONE_EN
              state     <= ST_CLEAR;
`else
              snap_busy <= 1'b0;
              snap_done <= 1'b1;
              state     <= ST_SWAP;
`endif
            end
          end else begin
            stall_cnt <= stall_cnt + SC_W'(1);
          end
        end
        ST_SWAP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  snapshot_bank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .we    (bank_we),
    .waddr (idx),
    .wdata (rf_dout),
    .swap  (bank_swap),
    .raddr (shadow_addr),
    .rdata (shadow_data)
  );

endmodule

// File: doc/sprite_snapshot_ctrl.md
Name: sprite_snapshot_ctrl

Overview:
Sits between the CPU bus and the sprite register file's single read/write port and arbitrates access between the CPU and an internal copy engine.
On each frame start, the engine copies sprite registers 0..16 into the back bank of a double-buffered shadow. It then swaps banks, so the renderer always reads a frame-consistent snapshot.
The CPU has priority. A stall limit bounds how long the copy can be starved.

Parameters:
NUM_REGS, 17, registers copied per snapshot (indices 0..NUM_REGS-1)
ADDR_W, 6, register-file address width
DATA_W, 8, register data width
STALL_LIMIT, 8, consecutive denied copy cycles before the engine forces a grant

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
vsync  in  1  one-cycle frame-start pulse
cpu_addr  in  ADDR_W  CPU register address
cpu_din  in  DATA_W  CPU write data
cpu_we  in  1  CPU write strobe
cpu_re  in  1  CPU read strobe
cpu_dout  out  DATA_W  read data, combinational from rf_dout
cpu_stall  out  1  combinational; CPU must hold its request this cycle
rf_addr  out  ADDR_W  register-file address
rf_din  out  DATA_W  register-file write data
rf_we  out  1  register-file write enable
rf_dout  in  DATA_W  register-file combinational read data
shadow_addr  in  5  renderer read index
shadow_data  out  DATA_W  front-bank data, combinational; 0 when index >= NUM_REGS
snap_busy  out  1  copy in progress
snap_done  out  1  one-cycle pulse on bank swap
snap_overrun  out  1  sticky flag: vsync arrived while busy

Behaviour:
- Reset values: state IDLE; idx 0; stall_cnt 0; front bank select 0; both banks all zero; snap_busy, snap_done, snap_overrun all 0.
- cpu_act = cpu_we | cpu_re.
- Grant rule: the engine owns the port when state is COPY (or CLEAR) and either !cpu_act or stall_cnt == STALL_LIMIT. Otherwise the CPU owns it.
  - When the CPU owns the port, rf_* pass cpu_* straight through. Any address is allowed, including status addresses with bit 5 set.
  - When the engine owns the port, cpu_stall = cpu_act and rf_we = 0 (rf_we = 1 only in CLEAR).
- States:
  - IDLE: on vsync, go to COPY with idx 0 and snap_busy 1.
  - COPY, granted cycle: rf_addr = idx. At the clock edge, back[idx] <= rf_dout and idx increments. On the grant with idx == NUM_REGS-1, go to SWAP.
  - COPY, denied cycle: stall_cnt increments. Any engine grant resets stall_cnt to 0.
  - SWAP: one cycle, no port use. Flip the front bank select, pulse snap_done, clear snap_busy, then go to IDLE.
- Latency: 17 cycles of copy plus 1 cycle of swap when the CPU is idle. With a continuously active CPU the copy takes NUM_REGS*(STALL_LIMIT+1) cycles before the swap.
- vsync while busy: set snap_overrun (sticky until reset). The copy continues unrestarted and no second copy is queued.
- vsync on the same cycle as the SWAP: also an overrun.
- A CPU write to index k after the engine has copied k is not reflected until the next frame. A CPU write to k before the copy reaches k is reflected.
- Shadow reads during a copy see only the front bank, so no torn data is visible.
- reset mid-copy: return to IDLE, zero both banks, leave front bank select at 0.

Optional Feature:
SNAP_WAIT_DONE_EN:
- Defined:
  - vsync moves IDLE to ARMED. ARMED passes all traffic to the CPU.
  - A CPU write to address 17 with nonzero data, while ARMED, moves to COPY on the next cycle.
  - After the last copy grant the engine enters CLEAR instead of SWAP. On CLEAR's granted cycle it writes 0 to address 17 (rf_we=1, rf_din=0), and CLEAR follows the same grant/stall rules as COPY. It then goes to SWAP.
  - vsync while ARMED sets snap_overrun.
- Undefined: the ARMED and CLEAR states do not exist, and address 17 has no special meaning.

Decomposition:
- Shared package: state encoding (IDLE, ARMED, COPY, CLEAR, SWAP), the constant 17 for the work-done index, and the NUM_REGS default.
- One sub-module, snapshot_bank: a 2 x NUM_REGS x DATA_W register array with a write port and a bank-select swap, giving the combinational front-bank read.

Test Plan:
1. Reset, preload regs 0..16 with values 0x10..0x20, CPU idle, pulse vsync -> snap_busy for 17 cycles; snap_done pulses at cycle 18; shadow_data[k] = 0x10+k.
2. CPU reads every cycle with STALL_LIMIT=8, then vsync -> each copy grant follows 8 denied cycles with cpu_stall high for exactly 1 cycle; swap occurs after 153 cycles.
3. During a copy, CPU writes reg 3 = 0xAA after idx passes 3 and reg 12 = 0xBB before idx reaches 12 -> snapshot shows reg 3 old value and reg 12 = 0xBB; shadow reads mid-copy return the previous snapshot.
4. Second vsync 5 cycles into a copy -> snap_overrun = 1 and stays 1; the copy finishes normally after one swap.
5. Assert reset at idx 9 -> next cycle: IDLE, shadow_data 0 for every index, snap_busy 0.
6. With SNAP_WAIT_DONE_EN: vsync, then CPU writes 0x01 to addr 17 -> copy starts the next cycle; the CLEAR cycle drives rf_we=1, rf_addr=17, rf_din=0; snap_done follows.
